pulse_gen_mc: RTL and testbench
===============================

PULSE_GEN_MC -- requirements
Module: pulse_gen_mc

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent pulse channels, 1..32.
REQ-002 Parameter CW, default 4: width of the pulse-width operand; maximum pulse length is 2^CW-1 cycles.
REQ-003 Parameter HOLDOFF, default 2: dead-time in cycles after a pulse (used only with PULSE_HOLDOFF_EN), 1..255.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sig  in  CHANNELS  per-channel trigger input; a rising edge triggers a pulse.
REQ-007 pw  in  CW  runtime pulse width in cycles, shared by all channels.
REQ-008 retrig  in  1  mode: 0 = ignore edges during a pulse, 1 = restart the pulse on an edge.
REQ-009 clr_missed  in  1  clears all missed flags.
REQ-010 pulse  out  CHANNELS  per-channel output pulse, registered (Moore).
REQ-011 missed  out  CHANNELS  sticky flag per channel: an edge was ignored.
REQ-012 busy  out  1  OR of all channels not in IDLE, registered-state derived.

Function
REQ-013 Each channel SHALL run an independent FSM with states IDLE, PULSE and, with the macro, HOLD; pulse SHALL be 1 only in PULSE.
REQ-014 Rising edge SHALL mean sig=1 at this clock edge and sig=0 at the previous clock edge, using a per-channel registered copy of sig.
REQ-015 Edge in IDLE at edge n SHALL move to PULSE; pulse high for cycles n+1 .. n+W, low at n+W+1 unless retriggered.
REQ-016 W SHALL be pw sampled at the triggering edge; pw=0 SHALL be treated as W=1; later pw changes SHALL NOT affect a running pulse.
REQ-017 Edge in PULSE with retrig=1 SHALL reload the counter with the current pw, so pulse stays high through n'+W' (n' = new edge).
REQ-018 Edge in PULSE with retrig=0 SHALL be ignored and SHALL set missed for that channel, including an edge on the final pulse cycle.
REQ-019 missed SHALL be set on the clock edge after the ignored edge; clr_missed SHALL clear it, and a set in the same cycle SHALL win over the clear.
REQ-020 Per-channel counters SHALL be CW bits, load W, decrement in PULSE and exit at 1, with no wrap-around.
REQ-021 Simultaneous edges on several channels SHALL be handled independently in the same cycle.
REQ-022 A sig level held high SHALL produce exactly one pulse.

Reset
REQ-023 While reset=1 all FSMs SHALL go to IDLE, counters to 0, pulse=0, missed=0, busy=0, effective the next clock edge.
REQ-024 The registered copy of sig SHALL reset to 1, so a sig already high at reset release does not trigger.
REQ-025 Reset asserted mid-pulse SHALL force pulse low on the next clock edge and discard the count.

Configuration
REQ-026 Macro PULSE_HOLDOFF_EN defined: PULSE SHALL exit to HOLD for exactly HOLDOFF cycles (pulse=0, busy=1), then return to IDLE.
REQ-027 In HOLD all edges SHALL be ignored and SHALL set missed regardless of retrig.
REQ-028 Macro PULSE_HOLDOFF_EN undefined: the HOLD state, its counter and the HOLDOFF logic SHALL NOT be built, and PULSE SHALL exit directly to IDLE.

Verification
REQ-029 Scenario: pw=3, retrig=0, sig[0] rises at edge 5 -> pulse[0] is 1 at edges 6,7,8 and 0 at edge 9; busy mirrors this.
REQ-030 Scenario: pw=3, retrig=0, a second rise on sig[0] at edge 7 -> pulse still ends after edge 8, missed[0]=1 from edge 8, and clr_missed at edge 12 gives missed[0]=0 at edge 13.
REQ-031 Scenario: pw=3, retrig=1, rises at edges 5 and 7 -> pulse[0] is high at edges 6..10 and low at edge 11, missed[0]=0.
REQ-032 Scenario: pw=0 -> one-cycle pulse; pw changed 3->7 mid-pulse -> length stays 3.
REQ-033 Scenario: reset at edge 7 during a pulse -> pulse=0 at edge 8; sig held high across reset release -> no pulse.
REQ-034 Scenario with PULSE_HOLDOFF_EN, HOLDOFF=2, pw=2: rise at edge 5 gives pulse at 6,7 and HOLD at 8,9; a rise at edge 9 sets missed; a rise at edge 11 triggers.

Source files
------------

// File: rtl/pulse_gen_mc_if.sv
// Pulse generator bus: trigger inputs, mode controls and pulse/status outputs.
interface pulse_gen_mc_if #(
   parameter int CHANNELS = 4,
   parameter int CW       = 4
);
   logic [CHANNELS-1:0] sig;
   logic [CW-1:0]       pw;
   logic                retrig;
   logic                clr_missed;
   logic [CHANNELS-1:0] pulse;
   logic [CHANNELS-1:0] missed;
   logic                busy;

   modport master (
      output sig, pw, retrig, clr_missed,
      input  pulse, missed, busy
   );

   modport slave (
      input  sig, pw, retrig, clr_missed,
      output pulse, missed, busy
   );
endinterface

// File: rtl/pulse_gen_mc.sv
// Multi-channel edge-triggered pulse generator with sticky missed-edge flags.
// Optional post-pulse dead time is built only when PULSE_HOLDOFF_EN is defined.
module pulse_gen_mc #(
   parameter int CHANNELS = 4,
   parameter int CW       = 4,
   parameter int HOLDOFF  = 2
) (
   input  logic           clock,
   input  logic           reset,
   pulse_gen_mc_if.slave  bus
);

   if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_ch
      $error("CHANNELS out of range");
   end
   if (CW < 1) begin : g_bad_cw
      $error("CW out of range");
   end
   if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_ho
      $error("HOLDOFF out of range");
   end

`ifdef PULSE_HOLDOFF_EN
   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLD} state_e;
`else
   typedef enum logic {S_IDLE, S_PULSE} state_e;
`endif

   state_e              state_q [CHANNELS];
   state_e              state_d [CHANNELS];
   logic [CW-1:0]       cnt_q   [CHANNELS];
   logic [CW-1:0]       cnt_d   [CHANNELS];
`ifdef PULSE_HOLDOFF_EN
   logic [7:0]          hold_q  [CHANNELS];
   logic [7:0]          hold_d  [CHANNELS];
`endif
   logic [CHANNELS-1:0] sig_q,    sig_d;
   logic [CHANNELS-1:0] pulse_q,  pulse_d;
   logic [CHANNELS-1:0] missed_q, missed_d;
   logic                busy_q,   busy_d;

   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] set_miss;
   logic [CHANNELS-1:0] active;
   logic [CW-1:0]       w_load;

   assign rise   = bus.sig & ~sig_q;
   assign sig_d  = bus.sig;
   // A zero width still yields a one-cycle pulse.
   assign w_load = (bus.pw == '0) ? CW'(1) : bus.pw;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
`ifdef PULSE_HOLDOFF_EN
      hold_d   = hold_q;
`endif
      set_miss = '0;
      active   = '0;
      pulse_d  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         unique case (state_q[i])
            S_IDLE: begin
               if (rise[i]) begin
                  state_d[i] = S_PULSE;
                  cnt_d[i]   = w_load;
               end
            end
            S_PULSE: begin
               if (rise[i] && bus.retrig) begin
                  cnt_d[i] = w_load;
               end else begin
                  set_miss[i] = rise[i];
                  if (cnt_q[i] == CW'(1)) begin
                     cnt_d[i] = '0;
`ifdef PULSE_HOLDOFF_EN
                     state_d[i] = S_HOLD;
                     hold_d[i]  = 8'(HOLDOFF);
`else
                     state_d[i] = S_IDLE;
`endif
                  end else begin
                     cnt_d[i] = cnt_q[i] - CW'(1);
                  end
               end
            end
`ifdef PULSE_HOLDOFF_EN
            S_HOLD: begin
               set_miss[i] = rise[i];
               if (hold_q[i] == 8'd1) begin
                  state_d[i] = S_IDLE;
                  hold_d[i]  = '0;
               end else begin
                  hold_d[i] = hold_q[i] - 8'd1;
               end
            end
`endif
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
         pulse_d[i] = (state_d[i] == S_PULSE);
         active[i]  = (state_d[i] != S_IDLE);
      end
      // A new miss in the same cycle beats the clear.
      missed_d = (missed_q & ~{CHANNELS{bus.clr_missed}}) | set_miss;
      busy_d   = |active;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= '{default: S_IDLE};
         cnt_q    <= '{default: '0};
`ifdef PULSE_HOLDOFF_EN
         hold_q   <= '{default: '0};
`endif
         sig_q    <= '1;
         pulse_q  <= '0;
         missed_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
`ifdef PULSE_HOLDOFF_EN
         hold_q   <= hold_d;
`endif
         sig_q    <= sig_d;
         pulse_q  <= pulse_d;
         missed_q <= missed_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.pulse  = pulse_q;
   assign bus.missed = missed_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Table-driven directed bench for pulse_gen_mc (4 channels, CW=4, HOLDOFF=2).
module tb_pulse_gen_mc;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   pulse_gen_mc_if #(.CHANNELS(4), .CW(4)) bus ();

   pulse_gen_mc #(.CHANNELS(4), .CW(4), .HOLDOFF(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic [3:0] sig;
      logic [3:0] pw;
      logic       rt;
      logic       clr;
      logic [3:0] ep;
      logic [3:0] em;
      logic       eb;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic [3:0] sig,
                      input logic [3:0] pw, input logic rt,
                      input logic clr, input logic [3:0] ep,
                      input logic [3:0] em, input logic eb);
      vec_t v;
      v.rst = rst; v.sig = sig; v.pw = pw; v.rt = rt;
      v.clr = clr; v.ep = ep; v.em = em; v.eb = eb;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int row,
                      input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row %0d: got %b want %b", nm, row, act, exp);
      end
   endtask

   initial begin
      bus.sig        = '0;
      bus.pw         = '0;
      bus.retrig     = 1'b0;
      bus.clr_missed = 1'b0;

      //  rst  sig     pw     rt clr  pulse   missed  busy
      // reset, then sig low after release
      add(1, 4'b0000, 4'd0, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0000, 4'd0, 0, 0, 4'b0000, 4'b0000, 0);
      // 3-cycle pulse, held level, re-rise on final cycle is missed
      add(0, 4'b0001, 4'd3, 0, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0001, 4'd3, 0, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0000, 4'd3, 0, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0001, 4'd3, 0, 0, 4'b0000, 4'b0001, 0);
      add(0, 4'b0001, 4'd3, 0, 1, 4'b0000, 4'b0000, 0);
      add(0, 4'b0000, 4'd3, 0, 0, 4'b0000, 4'b0000, 0);
      // pw=0 gives one cycle
      add(0, 4'b0010, 4'd0, 0, 0, 4'b0010, 4'b0000, 1);
      add(0, 4'b0000, 4'd0, 0, 0, 4'b0000, 4'b0000, 0);
      // two channels together; pw 3->7 mid-pulse keeps length 3
      add(0, 4'b1100, 4'd3, 0, 0, 4'b1100, 4'b0000, 1);
      add(0, 4'b0000, 4'd7, 0, 0, 4'b1100, 4'b0000, 1);
      add(0, 4'b0000, 4'd7, 0, 0, 4'b1100, 4'b0000, 1);
      add(0, 4'b0000, 4'd7, 0, 0, 4'b0000, 4'b0000, 0);
      // retrigger extends the pulse to 5 cycles
      add(0, 4'b0001, 4'd3, 1, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0000, 4'd3, 1, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0001, 4'd3, 1, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0000, 4'd3, 1, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0000, 4'd3, 1, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0000, 4'd3, 1, 0, 4'b0000, 4'b0000, 0);
      // set beats clear, flag sticky, then cleared
      add(0, 4'b0100, 4'd2, 0, 0, 4'b0100, 4'b0000, 1);
      add(0, 4'b0000, 4'd2, 0, 0, 4'b0100, 4'b0000, 1);
      add(0, 4'b0100, 4'd2, 0, 1, 4'b0000, 4'b0100, 0);
      add(0, 4'b0100, 4'd2, 0, 0, 4'b0000, 4'b0100, 0);
      add(0, 4'b0000, 4'd2, 0, 1, 4'b0000, 4'b0000, 0);
      // reset mid-pulse, sig held high across release
      add(0, 4'b1000, 4'd5, 0, 0, 4'b1000, 4'b0000, 1);
      add(1, 4'b1000, 4'd5, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1111, 4'd5, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1111, 4'd5, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0000, 4'd5, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0001, 4'd1, 0, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0000, 4'd1, 0, 0, 4'b0000, 4'b0000, 0);
`ifdef PULSE_HOLDOFF_EN
      // pw=2 then two hold cycles; edge in hold is missed
      add(0, 4'b0001, 4'd2, 0, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0000, 4'd2, 0, 0, 4'b0001, 4'b0000, 1);
      add(0, 4'b0000, 4'd2, 1, 0, 4'b0000, 4'b0000, 1);
      add(0, 4'b0001, 4'd2, 1, 0, 4'b0000, 4'b0001, 1);
      add(0, 4'b0000, 4'd2, 0, 0, 4'b0000, 4'b0001, 0);
      add(0, 4'b0001, 4'd2, 0, 0, 4'b0001, 4'b0001, 1);
`endif

      for (int r = 0; r < vq.size(); r++) begin
         reset          = vq[r].rst;
         bus.sig        = vq[r].sig;
         bus.pw         = vq[r].pw;
         bus.retrig     = vq[r].rt;
         bus.clr_missed = vq[r].clr;
         @(posedge clock);
         #1;
         chk("pulse",  r, bus.pulse,  vq[r].ep);
         chk("missed", r, bus.missed, vq[r].em);
         chk("busy",   r, {3'b000, bus.busy}, {3'b000, vq[r].eb});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
